// File: rtl/message_scheduler_if.sv
// Handshake bundle between the block producer, the SHA-256 message scheduler
// and the round consumer.
interface message_scheduler_if #(
    parameter int WORD_SIZE = 32
);
    logic                      block_valid;
    logic                      block_ready;
    logic [16*WORD_SIZE-1:0]   block_data;
    logic                      w_valid;
    logic                      w_ready;
    logic [WORD_SIZE-1:0]      w_out;
    logic [WORD_SIZE-1:0]      k_out;
    logic [5:0]                round_idx;
    logic                      w_last;

    // master: supplies blocks and consumes schedule words
    modport master (
        output block_valid, block_data, w_ready,
        input  block_ready, w_valid, w_out, k_out, round_idx, w_last
    );

    modport slave (
        input  block_valid, block_data, w_ready,
        output block_ready, w_valid, w_out, k_out, round_idx, w_last
    );
endinterface

// File: rtl/message_scheduler.sv
// SHA-256 message schedule: loads a 512-bit block into a 16-word sliding window
// and streams W_t with K_t for t = 0..63, extending the window on each transfer.
module message_scheduler #(
    parameter int WORD_SIZE = 32,
    parameter int ROUNDS    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    message_scheduler_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_reg;
    logic [5:0]           t_reg;
    logic [WORD_SIZE-1:0] window_reg [16];
    logic [WORD_SIZE-1:0] load_words [16];
    logic [WORD_SIZE-1:0] shift_words [16];
    logic [WORD_SIZE-1:0] new_word;
    logic [WORD_SIZE-1:0] k_word;
    logic                 load;
    logic                 xfer;
    logic                 last_t;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign load   = (state_reg == IDLE) && bus.block_valid;
    assign xfer   = (state_reg == RUN) && bus.w_ready;
    assign last_t = (t_reg == 6'(ROUNDS - 1));

    // Words beyond t=47 are computed but never reach w_out before the block ends.
    assign new_word = sig1(window_reg[14]) + window_reg[9] + sig0(window_reg[1]) + window_reg[0];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_window
            assign load_words[gi] = bus.block_data[(15-gi)*WORD_SIZE +: WORD_SIZE];
            if (gi == 15) begin : g_top
                assign shift_words[gi] = new_word;
            end else begin : g_mid
                assign shift_words[gi] = window_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            t_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.block_valid) begin
                        state_reg <= RUN;
                        t_reg     <= '0;
                    end
                end
                RUN: begin
                    if (bus.w_ready) begin
                        if (last_t) begin
                            state_reg <= IDLE;
                            t_reg     <= '0;
                        end else begin
                            t_reg <= t_reg + 6'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    t_reg     <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) window_reg[i] <= '0;
        end else if (load) begin
            window_reg <= load_words;
        end else if (xfer) begin
            window_reg <= shift_words;
        end
    end

    always_comb begin
        k_word = '0;
        case (t_reg)
            6'd0:  k_word = 32'h428a2f98;
            6'd1:  k_word = 32'h71374491;
            6'd2:  k_word = 32'hb5c0fbcf;
            6'd3:  k_word = 32'he9b5dba5;
            6'd4:  k_word = 32'h3956c25b;
            6'd5:  k_word = 32'h59f111f1;
            6'd6:  k_word = 32'h923f82a4;
            6'd7:  k_word = 32'hab1c5ed5;
            6'd8:  k_word = 32'hd807aa98;
            6'd9:  k_word = 32'h12835b01;
            6'd10: k_word = 32'h243185be;
            6'd11: k_word = 32'h550c7dc3;
            6'd12: k_word = 32'h72be5d74;
            6'd13: k_word = 32'h80deb1fe;
            6'd14: k_word = 32'h9bdc06a7;
            6'd15: k_word = 32'hc19bf174;
            6'd16: k_word = 32'he49b69c1;
            6'd17: k_word = 32'hefbe4786;
            6'd18: k_word = 32'h0fc19dc6;
            6'd19: k_word = 32'h240ca1cc;
            6'd20: k_word = 32'h2de92c6f;
            6'd21: k_word = 32'h4a7484aa;
            6'd22: k_word = 32'h5cb0a9dc;
            6'd23: k_word = 32'h76f988da;
            6'd24: k_word = 32'h983e5152;
            6'd25: k_word = 32'ha831c66d;
            6'd26: k_word = 32'hb00327c8;
            6'd27: k_word = 32'hbf597fc7;
            6'd28: k_word = 32'hc6e00bf3;
            6'd29: k_word = 32'hd5a79147;
            6'd30: k_word = 32'h06ca6351;
            6'd31: k_word = 32'h14292967;
            6'd32: k_word = 32'h27b70a85;
            6'd33: k_word = 32'h2e1b2138;
            6'd34: k_word = 32'h4d2c6dfc;
            6'd35: k_word = 32'h53380d13;
            6'd36: k_word = 32'h650a7354;
            6'd37: k_word = 32'h766a0abb;
            6'd38: k_word = 32'h81c2c92e;
            6'd39: k_word = 32'h92722c85;
            6'd40: k_word = 32'ha2bfe8a1;
            6'd41: k_word = 32'ha81a664b;
            6'd42: k_word = 32'hc24b8b70;
            6'd43: k_word = 32'hc76c51a3;
            6'd44: k_word = 32'hd192e819;
            6'd45: k_word = 32'hd6990624;
            6'd46: k_word = 32'hf40e3585;
            6'd47: k_word = 32'h106aa070;
            6'd48: k_word = 32'h19a4c116;
            6'd49: k_word = 32'h1e376c08;
            6'd50: k_word = 32'h2748774c;
            6'd51: k_word = 32'h34b0bcb5;
            6'd52: k_word = 32'h391c0cb3;
            6'd53: k_word = 32'h4ed8aa4a;
            6'd54: k_word = 32'h5b9cca4f;
            6'd55: k_word = 32'h682e6ff3;
            6'd56: k_word = 32'h748f82ee;
            6'd57: k_word = 32'h78a5636f;
            6'd58: k_word = 32'h84c87814;
            6'd59: k_word = 32'h8cc70208;
            6'd60: k_word = 32'h90befffa;
            6'd61: k_word = 32'ha4506ceb;
            6'd62: k_word = 32'hbef9a3f7;
            6'd63: k_word = 32'hc67178f2;
            default: k_word = '0;
        endcase
    end

    // All outputs come straight from state, t and the window, so a reset drops them at once.
    assign bus.block_ready = (state_reg == IDLE);
    assign bus.w_valid     = (state_reg == RUN);
    assign bus.w_out       = window_reg[0];
    assign bus.k_out       = k_word;
    assign bus.round_idx   = t_reg;
    assign bus.w_last      = (state_reg == RUN) && last_t;
endmodule

// File: tb/tb_message_scheduler.sv
// Directed and randomized checks of message_scheduler against a software
// SHA-256 schedule model, including the full "abc" digest.
module tb_message_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    message_scheduler_if #(.WORD_SIZE(32)) bus ();

    message_scheduler #(.WORD_SIZE(32), .ROUNDS(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          t;
        logic [31:0] w;
        logic [31:0] k;
        logic        last;
        bit          chk_w;
    } vec_t;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] got_w [64];
    logic [31:0] got_k [64];
    logic [5:0]  got_idx [64];
    logic        got_last [64];
    logic [31:0] exp_w [64];
    logic [31:0] kt [64];
    vec_t        vecs [7];

    localparam logic [511:0] ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    task automatic build_model(input logic [511:0] blk);
        for (int i = 0; i < 16; i++) exp_w[i] = blk[(15-i)*32 +: 32];
        for (int i = 16; i < 64; i++)
            exp_w[i] = ssig1(exp_w[i-2]) + exp_w[i-7] + ssig0(exp_w[i-15]) + exp_w[i-16];
    endtask

    // Runs the captured stream through one compression of the standard IV.
    function automatic logic [255:0] digest_of_stream();
        logic [31:0] hv [8];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        hv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
        e = hv[4]; f = hv[5]; g = hv[6]; hh = hv[7];
        for (int i = 0; i < 64; i++) begin
            t1 = hh + bsig1(e) + ((e & f) ^ (~e & g)) + got_k[i] + got_w[i];
            t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d,
                hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + hh};
    endfunction

    task automatic send_block(input string tag, input logic [511:0] blk);
        @(negedge clk);
        check({tag, " ready_before"}, 32'(bus.block_ready), 32'd1);
        bus.block_valid = 1'b1;
        bus.block_data  = blk;
        @(negedge clk);
        bus.block_valid = 1'b0;
        check({tag, " first_valid"}, 32'(bus.w_valid), 32'd1);
        check({tag, " first_idx"}, 32'(bus.round_idx), 32'd0);
    endtask

    // Consumes words at negedges; a transfer happens at the following posedge.
    task automatic stream(input string tag, input int stall_at, input int stall_len,
                          input bit rand_ready, input int intrude_at,
                          input logic [511:0] intr_blk, input int abort_at, output int n);
        int  cycles;
        int  stall_left;
        bit  stalled;
        bit  aborted;
        logic ready;
        n = 0; cycles = 0; stall_left = 0; stalled = 0; aborted = 0;
        while (n < 64 && cycles < 3000 && !aborted) begin
            @(negedge clk);
            cycles++;
            if (abort_at >= 0 && bus.w_valid && int'(bus.round_idx) == abort_at) begin
                rst_n = 1'b0;
                bus.w_ready = 1'b0;
                #1;
                check({tag, " abort_w_valid"}, 32'(bus.w_valid), 32'd0);
                check({tag, " abort_ready"}, 32'(bus.block_ready), 32'd1);
                check({tag, " abort_idx"}, 32'(bus.round_idx), 32'd0);
                aborted = 1;
            end else begin
                if (intrude_at >= 0 && bus.w_valid && int'(bus.round_idx) == intrude_at) begin
                    bus.block_valid = 1'b1;
                    bus.block_data  = intr_blk;
                end
                if (bus.block_valid)
                    check({tag, " busy_ready"}, 32'(bus.block_ready), 32'd0);
                if (stall_at >= 0 && !stalled && bus.w_valid && int'(bus.round_idx) == stall_at) begin
                    stall_left = stall_len;
                    stalled = 1;
                end
                if (stall_left > 0) begin
                    ready = 1'b0;
                    stall_left--;
                    check({tag, " stall_idx"}, 32'(bus.round_idx), 32'(stall_at));
                    check({tag, " stall_w"}, bus.w_out, exp_w[stall_at]);
                end else if (rand_ready) begin
                    ready = 1'($urandom_range(0, 1));
                end else begin
                    ready = 1'b1;
                end
                bus.w_ready = ready;
                if (bus.w_valid && ready) begin
                    got_w[n]    = bus.w_out;
                    got_k[n]    = bus.k_out;
                    got_idx[n]  = bus.round_idx;
                    got_last[n] = bus.w_last;
                    n++;
                end
            end
        end
        if (!aborted) begin
            if (n < 64) check({tag, " timeout_words"}, 32'(n), 32'd64);
            @(negedge clk);
            bus.w_ready = 1'b0;
            check({tag, " done_ready"}, 32'(bus.block_ready), 32'd1);
            check({tag, " done_valid"}, 32'(bus.w_valid), 32'd0);
        end
    endtask

    task automatic compare_stream(input string tag, input int n);
        check({tag, " count"}, 32'(n), 32'd64);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s w[%0d]", tag, i), got_w[i], exp_w[i]);
            check($sformatf("%s k[%0d]", tag, i), got_k[i], kt[i]);
            check($sformatf("%s idx[%0d]", tag, i), 32'(got_idx[i]), 32'(i));
            check($sformatf("%s last[%0d]", tag, i), 32'(got_last[i]), (i == 63) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        int n;
        logic [511:0] blk;
        logic [511:0] blk2;
        logic [255:0] dig;

        kt = '{
            32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
            32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
            32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
            32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
            32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
            32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
            32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
            32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

        vecs[0] = '{0,  32'h61626380, 32'h428a2f98, 1'b0, 1'b1};
        vecs[1] = '{1,  32'h00000000, 32'h71374491, 1'b0, 1'b1};
        vecs[2] = '{15, 32'h00000018, 32'hc19bf174, 1'b0, 1'b1};
        vecs[3] = '{16, 32'h61626380, 32'he49b69c1, 1'b0, 1'b1};
        vecs[4] = '{17, 32'h000f0000, 32'hefbe4786, 1'b0, 1'b1};
        vecs[5] = '{62, 32'h00000000, 32'hbef9a3f7, 1'b0, 1'b0};
        vecs[6] = '{63, 32'h00000000, 32'hc67178f2, 1'b1, 1'b0};

        bus.block_valid = 1'b0;
        bus.block_data  = '0;
        bus.w_ready     = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.block_ready), 32'd1);
        check("rst_in_valid", 32'(bus.w_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(bus.block_ready), 32'd1);
        check("rst_valid", 32'(bus.w_valid), 32'd0);
        check("rst_idx", 32'(bus.round_idx), 32'd0);
        check("rst_last", 32'(bus.w_last), 32'd0);
        check("rst_w", bus.w_out, 32'd0);
        check("rst_k", bus.k_out, 32'h428a2f98);

        // "abc" block without stalls
        build_model(ABC);
        send_block("abc", ABC);
        stream("abc", -1, 0, 1'b0, -1, '0, -1, n);
        compare_stream("abc", n);
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].chk_w)
                check($sformatf("vec t=%0d w", vecs[i].t), got_w[vecs[i].t], vecs[i].w);
            check($sformatf("vec t=%0d k", vecs[i].t), got_k[vecs[i].t], vecs[i].k);
            check($sformatf("vec t=%0d last", vecs[i].t), 32'(got_last[vecs[i].t]), 32'(vecs[i].last));
        end
        dig = digest_of_stream();
        for (int i = 0; i < 8; i++)
            check($sformatf("digest[%0d]", i), dig[(7-i)*32 +: 32], ABC_DIGEST[(7-i)*32 +: 32]);

        // backpressure at t=20 for 5 cycles
        send_block("stall", ABC);
        stream("stall", 20, 5, 1'b0, -1, '0, -1, n);
        compare_stream("stall", n);

        // second block offered during RUN at t=10
        blk2 = '0;
        for (int i = 0; i < 16; i++) blk2[i*32 +: 32] = $urandom;
        send_block("busy", ABC);
        stream("busy", -1, 0, 1'b0, 10, blk2, -1, n);
        compare_stream("busy", n);
        @(negedge clk);
        bus.block_valid = 1'b0;
        check("busy2 accepted", 32'(bus.w_valid), 32'd1);
        check("busy2 idx", 32'(bus.round_idx), 32'd0);
        build_model(blk2);
        stream("busy2", -1, 0, 1'b0, -1, '0, -1, n);
        compare_stream("busy2", n);

        // reset at t=30, then a fresh block
        build_model(ABC);
        send_block("abort", ABC);
        stream("abort", -1, 0, 1'b0, -1, '0, 30, n);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_block("restart", ABC);
        stream("restart", -1, 0, 1'b0, -1, '0, -1, n);
        compare_stream("restart", n);

        // random blocks with random w_ready
        for (int b = 0; b < 10; b++) begin
            for (int i = 0; i < 16; i++) blk[i*32 +: 32] = $urandom;
            build_model(blk);
            send_block($sformatf("rnd%0d", b), blk);
            stream($sformatf("rnd%0d", b), -1, 0, 1'b1, -1, '0, -1, n);
            compare_stream($sformatf("rnd%0d", b), n);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
